// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: stalls the pipeline for LATENCY wait cycles,
// then presents a size/sign-extended load result. Misaligned or illegal accesses are flagged and dropped.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreqM,
  input  logic        memwriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] aluresultM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        misalignM
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  generate
    if (LATENCY < 1) begin : g_bad_latency
      $error("dmem_responder: LATENCY must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW+1:0]   addr_q;
  logic [2:0]      f3_q;
  logic [31:0]     wdat_q;
  logic            we_q;
  logic [31:0]     rdata_q, rdata_d;

  logic [31:0]     mem [DEPTH_WORDS];

  logic            legal;
  logic            accept;
  logic            do_acc;
  logic [31:0]     rword;
  logic [31:0]     wword;
  logic [7:0]      bsel;
  logic [15:0]     hsel;
  logic            unused_addr;

  assign unused_addr = ^aluresultM[31:AW+2];

  // Size comes from funct3[1:0]; unsigned variants only exist for loads.
  always_comb begin
    legal = 1'b0;
    case (funct3M)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~aluresultM[0];
      3'b010:  legal = (aluresultM[1:0] == 2'b00);
      3'b100:  legal = ~memwriteM;
      3'b101:  legal = ~memwriteM & ~aluresultM[0];
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stallM    = 1'b0;
    misalignM = 1'b0;
    accept    = 1'b0;
    do_acc    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (memreqM) begin
          if (legal) begin
            accept  = 1'b1;
            stallM  = 1'b1;
            cnt_d   = CW'(LATENCY - 1);
            state_d = ST_WAIT;
          end else begin
            misalignM = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        stallM = 1'b1;
        if (cnt_q == '0) begin
          do_acc  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign rword = mem[addr_q[AW+1:2]];
  assign bsel  = rword[8*addr_q[1:0] +: 8];
  assign hsel  = addr_q[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    rdata_d = rdata_q;
    if (do_acc && !we_q) begin
      case (f3_q)
        3'b000:  rdata_d = {{24{bsel[7]}}, bsel};
        3'b001:  rdata_d = {{16{hsel[15]}}, hsel};
        3'b100:  rdata_d = {24'd0, bsel};
        3'b101:  rdata_d = {16'd0, hsel};
        default: rdata_d = rword;
      endcase
    end
  end

  // Read-modify-write merge so untouched lanes keep their contents.
  always_comb begin
    wword = rword;
    case (f3_q[1:0])
      2'b00: wword[8*addr_q[1:0] +: 8] = wdat_q[7:0];
      2'b01: begin
        if (addr_q[1]) wword[31:16] = wdat_q[15:0];
        else           wword[15:0]  = wdat_q[15:0];
      end
      default: wword = wdat_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      f3_q    <= 3'b000;
      wdat_q  <= 32'd0;
      we_q    <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      if (accept) begin
        addr_q <= aluresultM[AW+1:0];
        f3_q   <= funct3M;
        wdat_q <= writedataM;
        we_q   <= memwriteM;
      end
    end
  end

  // Array is deliberately outside the reset domain; reset in WAIT kills do_acc before the edge.
  always_ff @(posedge clk) begin
    if (do_acc && we_q) begin
      mem[addr_q[AW+1:2]] <= wword;
    end
  end

  assign readdataM = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: round trips of each access size, misalignment rejection,
// reset during an access and address wrap, all against hand-computed values.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        memreqM;
  logic        memwriteM;
  logic [2:0]  funct3M;
  logic [31:0] aluresultM;
  logic [31:0] writedataM;
  logic [31:0] readdataM;
  logic        stallM;
  logic        misalignM;

  int checks = 0;
  int errors = 0;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .memreqM    (memreqM),
    .memwriteM  (memwriteM),
    .funct3M    (funct3M),
    .aluresultM (aluresultM),
    .writedataM (writedataM),
    .readdataM  (readdataM),
    .stallM     (stallM),
    .misalignM  (misalignM)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one legal access, holding memreqM through DONE, and checks stall length and result.
  task automatic do_access(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd);
    int n;
    @(negedge clk);
    memreqM = 1'b1; memwriteM = we; funct3M = f3; aluresultM = a; writedataM = wd;
    #1;
    n = 0;
    while (stallM && n < 20) begin
      n++;
      @(negedge clk);
      #1;
    end
    check_eq({tag, "_stall_cycles"}, n, LAT + 1);
    check_eq({tag, "_misalign"}, {31'd0, misalignM}, 32'd0);
    check_eq({tag, "_readdata"}, readdataM, exp_rd);
    memreqM = 1'b0;
  endtask

  // Presents an illegal access for two cycles; nothing may change.
  task automatic do_illegal(input string tag, input logic we, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] exp_rd);
    @(negedge clk);
    memreqM = 1'b1; memwriteM = we; funct3M = f3; aluresultM = a; writedataM = 32'h12345678;
    #1;
    check_eq({tag, "_misalign"}, {31'd0, misalignM}, 32'd1);
    check_eq({tag, "_stall"}, {31'd0, stallM}, 32'd0);
    @(negedge clk);
    #1;
    check_eq({tag, "_stall_held"}, {31'd0, stallM}, 32'd0);
    check_eq({tag, "_readdata"}, readdataM, exp_rd);
    memreqM = 1'b0;
  endtask

  initial begin
    reset = 1'b0; memreqM = 1'b0; memwriteM = 1'b0; funct3M = 3'b000;
    aluresultM = 32'd0; writedataM = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_readdata", readdataM, 32'd0);
    check_eq("rst_stall", {31'd0, stallM}, 32'd0);
    check_eq("rst_misalign", {31'd0, misalignM}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_eq("post_rst_readdata", readdataM, 32'd0);
    check_eq("post_rst_stall", {31'd0, stallM}, 32'd0);

    do_access("sw_10",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h00000000);
    do_access("lw_10a", 1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF);

    do_access("sb_13",  1'b1, 3'b000, 32'h13, 32'h00000080, 32'hDEADBEEF);
    do_access("lb_13",  1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFF80);
    do_access("lbu_13", 1'b0, 3'b100, 32'h13, 32'h0,        32'h00000080);
    do_access("lw_10b", 1'b0, 3'b010, 32'h10, 32'h0,        32'h80ADBEEF);

    do_access("sh_12",  1'b1, 3'b001, 32'h12, 32'h00008001, 32'h80ADBEEF);
    do_access("lh_12",  1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFF8001);
    do_access("lhu_12", 1'b0, 3'b101, 32'h12, 32'h0,        32'h00008001);
    do_access("lw_10c", 1'b0, 3'b010, 32'h10, 32'h0,        32'h8001BEEF);
    do_access("lb_10",  1'b0, 3'b000, 32'h10, 32'h0,        32'hFFFFFFEF);
    do_access("lhu_10", 1'b0, 3'b101, 32'h10, 32'h0,        32'h0000BEEF);
    do_access("lbu_11", 1'b0, 3'b100, 32'h11, 32'h0,        32'h000000BE);

    do_illegal("lw_11",   1'b0, 3'b010, 32'h11, 32'h000000BE);
    do_illegal("sw_12",   1'b1, 3'b010, 32'h12, 32'h000000BE);
    do_illegal("f3_011",  1'b0, 3'b011, 32'h10, 32'h000000BE);
    do_illegal("st_lbu",  1'b1, 3'b100, 32'h10, 32'h000000BE);
    do_illegal("lh_13",   1'b0, 3'b001, 32'h13, 32'h000000BE);
    do_access("lw_10d", 1'b0, 3'b010, 32'h10, 32'h0, 32'h8001BEEF);

    do_access("sw_20", 1'b1, 3'b010, 32'h20, 32'h0BADF00D, 32'h8001BEEF);
    @(negedge clk);
    memreqM = 1'b1; memwriteM = 1'b1; funct3M = 3'b010; aluresultM = 32'h20; writedataM = 32'hCAFEF00D;
    @(negedge clk);
    memreqM = 1'b0;
    #1;
    check_eq("rst_mid_wait_stall", {31'd0, stallM}, 32'd1);
    reset = 1'b0;
    #1;
    check_eq("rst_mid_stall", {31'd0, stallM}, 32'd0);
    check_eq("rst_mid_readdata", readdataM, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    do_access("lw_20", 1'b0, 3'b010, 32'h20, 32'h0, 32'h0BADF00D);

    do_access("sw_1000", 1'b1, 3'b010, 32'h1000, 32'h11112222, 32'h0BADF00D);
    do_access("lw_0",    1'b0, 3'b010, 32'h0,    32'h0,        32'h11112222);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
